instr_fetch_buffer: RTL

- Consumes the program counter produced by the fetch/PC unit and issues single-outstanding word requests to instruction memory.
- Captures each returned instruction together with its PC in a DEPTH-entry FIFO.
- Presents the FIFO head to the decode stage over a valid/ready handshake.
- A flush input discards all buffered and in-flight instructions on a control-flow redirect.

---
 rtl/instr_fetch_buffer_if.sv | 33 +++
 rtl/instr_fetch_buffer.sv | 116 +++++++++++
 2 files changed

// File: rtl/instr_fetch_buffer_if.sv
// Bus bundle between the fetch buffer and its PC source, instruction memory and decode stage.
// The master modport is the fetch buffer's view; slave is the environment's view.
interface instr_fetch_buffer_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] pc_in;
  logic            pc_valid;
  logic            pc_ready;
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;
  logic            flush;
  logic            dec_valid;
  logic [XLEN-1:0] dec_pc;
  logic [XLEN-1:0] dec_instr;
  logic            dec_ready;
  logic [CW-1:0]   count;

  modport master (
    input  pc_in, pc_valid, imem_req_ready, imem_resp_valid, imem_resp_data, flush, dec_ready,
    output pc_ready, imem_req_valid, imem_req_addr, dec_valid, dec_pc, dec_instr, count
  );

  modport slave (
    output pc_in, pc_valid, imem_req_ready, imem_resp_valid, imem_resp_data, flush, dec_ready,
    input  pc_ready, imem_req_valid, imem_req_addr, dec_valid, dec_pc, dec_instr, count
  );
endinterface

// File: rtl/instr_fetch_buffer.sv
// Single-outstanding instruction fetcher feeding a DEPTH-entry {pc, instr} FIFO for decode.
// Flush empties the FIFO and marks any in-flight response to be dropped.
module instr_fetch_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic              clk,
  input  logic              reset,
  instr_fetch_buffer_if.master bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t          state;
  state_t          next_state;
  logic            drop;
  logic            req_valid;
  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic pc_ready;
  logic accept;
  logic push;
  logic dec_valid;
  logic pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept)              next_state = REQ;
      REQ:     if (bus.imem_req_ready)  next_state = WAIT;
      WAIT:    if (bus.imem_resp_valid) next_state = IDLE;
      default:                          next_state = IDLE;
    endcase
  end

  // The acceptance check on count reserves the slot the single outstanding response will fill.
  always_comb begin
    pc_ready  = 1'b0;
    push      = 1'b0;
    unique case (state)
      IDLE:    pc_ready = (count < CW'(DEPTH)) && !bus.flush;
      WAIT:    push     = bus.imem_resp_valid && !drop && !bus.flush;
      default: ;
    endcase
    accept    = pc_ready && bus.pc_valid;
    dec_valid = (count != '0) && !bus.flush;
    pop       = dec_valid && bus.dec_ready;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_valid <= 1'b0;
      req_pc    <= '0;
      req_addr  <= '0;
      drop      <= 1'b0;
    end else begin
      req_valid <= (next_state == REQ);
      if (accept) begin
        req_pc   <= bus.pc_in;
        req_addr <= {bus.pc_in[XLEN-1:2], 2'b00};
      end
      // A response landing in the flush cycle is already discarded, so drop is not armed for it.
      if (state == WAIT && bus.imem_resp_valid) drop <= 1'b0;
      else if (bus.flush && state != IDLE)      drop <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]    <= req_pc;
        instr_mem[wr_ptr] <= bus.imem_resp_data;
        wr_ptr            <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  assign bus.pc_ready       = pc_ready;
  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = req_addr;
  assign bus.dec_valid      = dec_valid;
  assign bus.dec_pc         = pc_mem[rd_ptr];
  assign bus.dec_instr      = instr_mem[rd_ptr];
  assign bus.count          = count;
endmodule
